ldm_writeback_seq: RTL and testbench
====================================

# ldm_writeback_seq

Write-back sequencer that drives the register file's write port (`writeBackEn`, `Dest_wb`, `Result_WB`). It forwards ordinary single-register results from the MEM/WB pipeline stage. For block loads (LDM-style), it takes a 16-bit register list and a stream of data words over a valid/ready handshake, and writes each word to the next listed register in ascending order while holding the pipeline stalled. The register file commits on the negative clock edge, so all write-port outputs are registered on the rising edge and are stable before the commit edge.

## Interface
- No parameters; widths are fixed by the register file (16 × 32-bit registers).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `wb_en_in` in 1: single-write request from the pipeline.
- `wb_dest_in` in 4: destination register of the single write.
- `wb_value_in` in 32: value of the single write.
- `blk_start` in 1: start a block load; sampled only in IDLE.
- `blk_list` in 16: register list, bit i = Ri; sampled with `blk_start`.
- `blk_base_reg` in 4: base register index; sampled with `blk_start`.
- `blk_base_addr` in 32: base address; sampled with `blk_start`.
- `data_valid` in 1: load data word available.
- `data_in` in 32: load data word.
- `data_ready` out 1: sequencer accepts a data word this cycle.
- `busy` out 1: pipeline must stall; equals state != IDLE.
- `done` out 1: one-cycle pulse marking the final write of a block.
- `writeBackEn` out 1: register-file write enable.
- `Dest_wb` out 4: register-file write index.
- `Result_WB` out 32: register-file write data.

## Operation
- States: IDLE, BLOCK, BASE_WB. BASE_WB exists only when `LDM_WRITEBACK_EN` is defined.
- IDLE with `wb_en_in`=1:
  - next cycle `writeBackEn`=1, `Dest_wb`=`wb_dest_in`, `Result_WB`=`wb_value_in`;
  - otherwise `writeBackEn`=0.
- IDLE with `blk_start`=1:
  - latch the list, base register, and base address;
  - latch `cnt` = popcount(`blk_list`), 5 bits, range 0..16;
  - go to BLOCK if the list is non-zero.
- Same cycle `wb_en_in` and `blk_start`: the single write is still issued next cycle, and the block also starts.
- `wb_en_in` in any non-IDLE state is ignored and not queued. The pipeline is responsible for honouring `busy`.
- BLOCK:
  - `data_ready`=1.
  - On each `data_valid && data_ready`, next cycle write `data_in` to the lowest set bit of the remaining list, then clear that bit.
  - `data_valid`=0 produces a bubble: `writeBackEn`=0 and the state holds.
- Last set bit consumed: go to IDLE, or to BASE_WB with the macro. Without the macro, `done` pulses with that last write.
- BASE_WB, one cycle:
  - write `blk_base_addr + {cnt,2'b00}` (mod 2^32, wrap-around ignored) to `blk_base_reg`;
  - `done` pulses with this write;
  - go to IDLE.
- Base register also in the list: the list write happens first and is then overwritten by BASE_WB (base writeback wins).
- Empty list (`blk_start`, list=0):
  - without the macro: no writes, `done` pulses next cycle, state stays IDLE, `busy` stays 0;
  - with the macro: go directly to BASE_WB, which writes `blk_base_addr` unchanged.

## Timing
- Reset (async, `rst`=0) forces the following immediately:
  - state=IDLE; remaining list cleared;
  - `writeBackEn`=0, `Dest_wb`=0, `Result_WB`=0;
  - `data_ready`=0, `busy`=0, `done`=0.
- Reset mid-block aborts the block. No further writes occur, and registers already written stay written.
- Single-write latency is 1 cycle: input at rising edge N, output valid from N until edge N+1, committed at the intervening negedge.
- Block load:
  - `data_ready` rises one cycle after `blk_start`;
  - each write appears 1 cycle after its handshake;
  - back-to-back words sustain 1 write per cycle.
- `data_ready` drops in the same cycle as the final write.
- Minimum block duration is N+1 cycles for N listed registers, plus 1 with BASE_WB.
- All outputs are registered; `busy` and `data_ready` are decoded from the state register only.

## Configuration
- `LDM_WRITEBACK_EN`:
  - Defined: BASE_WB state and base-register update are compiled in; `done` accompanies the base write.
  - Undefined: BASE_WB is absent; `blk_base_reg`/`blk_base_addr` are unused, and `done` accompanies the last list write.

## Test plan
- Reset then single write `wb_en_in`=1, dest=5, value=0xDEADBEEF: the next cycle shows `writeBackEn`=1, `Dest_wb`=5, `Result_WB`=0xDEADBEEF. The following cycle shows `writeBackEn`=0.
- Block list=0x8091, data 0xA,0xB,0xC,0xD back-to-back: writes R0=0xA, R4=0xB, R7=0xC, R15=0xD on consecutive cycles, and `done` pulses with the R15 write. With the macro, the next cycle writes base=R13 with 0x1000+16=0x1010.
- Block list=0x0006 with `data_valid` low for 3 cycles between words: `writeBackEn` stays 0 during the gaps, writes go to R1 then R2, and `busy` stays 1 throughout.
- `wb_en_in` asserted while `busy`=1: no write to its destination appears at any time.
- Empty list: without the macro, `done` pulses next cycle and `busy` stays 0. With the macro, one write of `blk_base_addr` to the base register.
- Reset asserted after 2 of 4 words: outputs go to 0 immediately, and after release the state is IDLE, `data_ready`=0, and no further writes occur.

Source files
------------

// File: rtl/ldm_writeback_seq.sv
// Register-file write-back sequencer: forwards single MEM/WB writes and serialises LDM block loads.
// Optional LDM_WRITEBACK_EN adds a BASE_WB state that writes base_addr + 4*count to the base register.
module ldm_writeback_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic [3:0]  wb_dest_in,
  input  logic [31:0] wb_value_in,
  input  logic        blk_start,
  input  logic [15:0] blk_list,
  input  logic [3:0]  blk_base_reg,
  input  logic [31:0] blk_base_addr,
  input  logic        data_valid,
  input  logic [31:0] data_in,
  output logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic        writeBackEn,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_WB
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BLOCK   = 2'd1;
`ifdef LDM_WRITEBACK_EN
  localparam logic [1:0] BASE_WB = 2'd2;
`endif

  logic [1:0]  state;
  logic [15:0] rem_list;

  function automatic logic [3:0] low_idx(input logic [15:0] v);
    low_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) low_idx = 4'(i);
  endfunction

`ifdef LDM_WRITEBACK_EN
  logic [4:0]  cnt;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;

  function automatic logic [4:0] pop16(input logic [15:0] v);
    pop16 = '0;
    for (int i = 0; i < 16; i++)
      pop16 = pop16 + 5'(v[i]);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      base_reg  <= '0;
      base_addr <= '0;
    end else if (state == IDLE && blk_start) begin
      cnt       <= pop16(blk_list);
      base_reg  <= blk_base_reg;
      base_addr <= blk_base_addr;
    end
  end
`else
  logic unused_base;
  assign unused_base = ^{blk_base_reg, blk_base_addr};
`endif

  // Status decoded from state only so the pipeline stall never depends on inputs.
  assign busy       = (state != IDLE);
  assign data_ready = (state == BLOCK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rem_list    <= '0;
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
      done        <= 1'b0;
    end else begin
      writeBackEn <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_en_in) begin
            writeBackEn <= 1'b1;
            Dest_wb     <= wb_dest_in;
            Result_WB   <= wb_value_in;
          end
          if (blk_start) begin
            rem_list <= blk_list;
            if (blk_list != '0)
              state <= BLOCK;
            else begin
`ifdef LDM_WRITEBACK_EN
              state <= BASE_WB;
`else
              done  <= 1'b1;
`endif
            end
          end
        end
        BLOCK: begin
          if (data_valid) begin
            writeBackEn <= 1'b1;
            Dest_wb     <= low_idx(rem_list);
            Result_WB   <= data_in;
            rem_list    <= rem_list & (rem_list - 16'd1);
            // Only one bit left: this word finishes the list.
            if ((rem_list & (rem_list - 16'd1)) == '0) begin
`ifdef LDM_WRITEBACK_EN
              state <= BASE_WB;
`else
              state <= IDLE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef LDM_WRITEBACK_EN
        BASE_WB: begin
          writeBackEn <= 1'b1;
          Dest_wb     <= base_reg;
          Result_WB   <= base_addr + {25'd0, cnt, 2'b00};
          done        <= 1'b1;
          state       <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldm_writeback_seq.sv
// Scoreboard bench for ldm_writeback_seq: directed stimulus pushes expected writes, a negedge monitor checks them.
module tb_ldm_writeback_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en_in = 1'b0;
  logic [3:0]  wb_dest_in = '0;
  logic [31:0] wb_value_in = '0;
  logic        blk_start = 1'b0;
  logic [15:0] blk_list = '0;
  logic [3:0]  blk_base_reg = '0;
  logic [31:0] blk_base_addr = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_ready, busy, done, writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;

  ldm_writeback_seq dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .wb_dest_in(wb_dest_in),
    .wb_value_in(wb_value_in), .blk_start(blk_start), .blk_list(blk_list),
    .blk_base_reg(blk_base_reg), .blk_base_addr(blk_base_addr),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
    .busy(busy), .done(done), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
    .Result_WB(Result_WB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  dest;
    logic [31:0] val;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

`ifdef LDM_WRITEBACK_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic push(input logic we, input logic [3:0] d, input logic [31:0] v, input logic dn);
    exp_t e;
    e.we = we; e.dest = d; e.val = v; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any write or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (writeBackEn || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {27'd0, writeBackEn, Dest_wb}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_en", {31'd0, writeBackEn}, {31'd0, e.we});
        chk("done", {31'd0, done}, {31'd0, e.done});
        if (e.we) begin
          chk("dest", {28'd0, Dest_wb}, {28'd0, e.dest});
          chk("value", Result_WB, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_wben", {31'd0, writeBackEn}, 32'd0);
    chk("rst_dest", {28'd0, Dest_wb}, 32'd0);
    chk("rst_result", Result_WB, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();

    // Single write
    wb_en_in = 1'b1; wb_dest_in = 4'd5; wb_value_in = 32'hDEADBEEF;
    push(1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
    tick();
    wb_en_in = 1'b0;
    tick();
    chk("single_off", {31'd0, writeBackEn}, 32'd0);

    // Block 0x8091 back-to-back
    blk_start = 1'b1; blk_list = 16'h8091; blk_base_reg = 4'd13; blk_base_addr = 32'h1000;
    tick();
    blk_start = 1'b0;
    chk("blk_ready", {31'd0, data_ready}, 32'd1);
    chk("blk_busy", {31'd0, busy}, 32'd1);
    data_valid = 1'b1;
    data_in = 32'hA; push(1'b1, 4'd0, 32'hA, 1'b0); tick();
    data_in = 32'hB; push(1'b1, 4'd4, 32'hB, 1'b0); tick();
    data_in = 32'hC; push(1'b1, 4'd7, 32'hC, 1'b0); tick();
    data_in = 32'hD; push(1'b1, 4'd15, 32'hD, !MAC);
    if (MAC) push(1'b1, 4'd13, 32'h1010, 1'b1);
    tick();
    data_valid = 1'b0;
    chk("blk_ready_drop", {31'd0, data_ready}, 32'd0);
    tick(); tick();
    chk("blk_idle", {31'd0, busy}, 32'd0);

    // Block 0x0006 with gaps; wb_en_in while busy must be dropped
    blk_start = 1'b1; blk_list = 16'h0006; blk_base_reg = 4'd2; blk_base_addr = 32'h2000;
    tick();
    blk_start = 1'b0;
    data_valid = 1'b1; data_in = 32'h11; push(1'b1, 4'd1, 32'h11, 1'b0);
    tick();
    data_valid = 1'b0;
    wb_en_in = 1'b1; wb_dest_in = 4'd9; wb_value_in = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_busy", {31'd0, busy}, 32'd1);
      chk("gap_wben", {31'd0, writeBackEn}, 32'd0);
    end
    data_valid = 1'b1; data_in = 32'h22; push(1'b1, 4'd2, 32'h22, !MAC);
    if (MAC) push(1'b1, 4'd2, 32'h2008, 1'b1);
    tick();
    wb_en_in = 1'b0;
    data_valid = 1'b0;
    tick(); tick();

    // Empty list
    blk_start = 1'b1; blk_list = 16'h0000; blk_base_reg = 4'd3; blk_base_addr = 32'h3000;
    if (MAC) push(1'b1, 4'd3, 32'h3000, 1'b1);
    else push(1'b0, 4'd0, 32'd0, 1'b1);
    tick();
    blk_start = 1'b0;
    chk("empty_busy", {31'd0, busy}, {31'd0, MAC});
    tick(); tick();

    // Reset after 2 of 4 words
    blk_start = 1'b1; blk_list = 16'h000F; blk_base_reg = 4'd6; blk_base_addr = 32'h4000;
    tick();
    blk_start = 1'b0;
    data_valid = 1'b1;
    data_in = 32'h51; push(1'b1, 4'd0, 32'h51, 1'b0); tick();
    data_in = 32'h52; push(1'b1, 4'd1, 32'h52, 1'b0); tick();
    data_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_wben", {31'd0, writeBackEn}, 32'd0);
    chk("arst_dest", {28'd0, Dest_wb}, 32'd0);
    chk("arst_result", Result_WB, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, data_ready}, 32'd0);
    #4 rst = 1'b1;
    tick();
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_ready", {31'd0, data_ready}, 32'd0);
    data_valid = 1'b1; data_in = 32'h53;
    tick(); tick();
    data_valid = 1'b0;
    tick(); tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
